// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS controller with memory handshake:
// opcode/funct constants, FSM state encoding, ALU codes and datapath selects.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_DATA   = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JEX     = 4'd12,
    S_JALEX   = 4'd13,
    S_TRAP    = 4'd14
  } state_t;

  // Internal ALU-op field handed from the FSM to the ALU decoder.
  typedef enum logic [2:0] {
    ALUOP_NONE  = 3'd0,
    ALUOP_ADD   = 3'd1,
    ALUOP_SUB   = 3'd2,
    ALUOP_FUNCT = 3'd3,
    ALUOP_IMM   = 3'd4
  } aluop_t;

endpackage

// File: rtl/mips_mc_ctrl_ws_aludec.sv
// Combinational ALU decoder: maps the FSM's ALU-op field, the opcode (for
// immediate ops) and funct (for R-type) onto alucontrol, and flags legal funct.
module mips_aludec_ext
  import mips_mc_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output logic [2:0]  alucontrol,
  output logic        funct_legal
);

  logic [2:0] fn_ctl;
  logic [2:0] imm_ctl;

  // Decode funct and immediate opcode, then select by ALU-op field.
  always_comb begin
    funct_legal = 1'b1;
    fn_ctl      = ALU_ADD;
    case (funct)
      FN_ADD:  fn_ctl = ALU_ADD;
      FN_SUB:  fn_ctl = ALU_SUB;
      FN_AND:  fn_ctl = ALU_AND;
      FN_OR:   fn_ctl = ALU_OR;
      FN_SLT:  fn_ctl = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase

    imm_ctl = ALU_ADD;
    case (op)
      OP_SLTI: imm_ctl = ALU_SLT;
      OP_ANDI: imm_ctl = ALU_AND;
      OP_ORI:  imm_ctl = ALU_OR;
      default: imm_ctl = ALU_ADD;
    endcase

    case (aluop)
      ALUOP_ADD:   alucontrol = ALU_ADD;
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: alucontrol = fn_ctl;
      ALUOP_IMM:   alucontrol = imm_ctl;
      default:     alucontrol = 3'b000;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl_ws.sv
// Multicycle MIPS control unit with variable-latency memory handshake,
// BNE/SLTI/ANDI/ORI/JAL support and an optional memory-timeout trap.
// Define MIPS_MC_PERF_EN to add the retired-instruction counter port instret.
module mips_mc_ctrl_ws
  import mips_mc_pkg::*;
#(
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              memwrite,
  output logic              pcen,
  output logic              irwrite,
  output logic              regwrite,
  output logic              alusrca,
  output logic              iord,
  output logic              immext,
  output logic [1:0]        regdst,
  output logic [1:0]        memtoreg,
  output logic [1:0]        alusrcb,
  output logic [1:0]        pcsrc,
  output logic [2:0]        alucontrol,
  output logic              fault
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [CNT_W-1:0]  instret
`endif
);

  state_t      state, next_state;
  logic [31:0] wait_cnt;
  logic        waiting;
  logic        timed_out;
  aluop_t      aluop;
  logic        funct_legal;

  mips_aludec_ext u_aludec (
    .aluop       (aluop),
    .op          (op),
    .funct       (funct),
    .alucontrol  (alucontrol),
    .funct_legal (funct_legal)
  );

  // A memory-facing state is stalled on the handshake this cycle.
  assign waiting = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                   && !mem_ready;
  // This wait cycle is the TIMEOUT-th one; a simultaneous ready never gets here.
  assign timed_out = (TIMEOUT > 0) && waiting && (wait_cnt >= 32'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Wait counter: cleared on any state change, counts stalled cycles, saturates.
  always_ff @(posedge clk) begin
    if (reset)                         wait_cnt <= '0;
    else if (next_state != state)      wait_cnt <= '0;
    else if (waiting && wait_cnt != '1) wait_cnt <= wait_cnt + 32'd1;
  end

`ifdef MIPS_MC_PERF_EN
  // Count instructions completing back into FETCH; FETCH self-loops are stalls.
  always_ff @(posedge clk) begin
    if (reset)                                         instret <= '0;
    else if (state != S_FETCH && next_state == S_FETCH) instret <= instret + CNT_W'(1);
  end
`endif

  // Next-state and control outputs; all outputs forced low while in reset.
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    immext     = 1'b0;
    regdst     = REGDST_RT;
    memtoreg   = MEMTOREG_ALUOUT;
    alusrcb    = ALUSRCB_B;
    pcsrc      = PCSRC_ALURES;
    aluop      = ALUOP_NONE;
    fault      = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          irwrite    = 1'b1;
          pcen       = 1'b1;
          alusrcb    = ALUSRCB_FOUR;
          pcsrc      = PCSRC_ALURES;
          aluop      = ALUOP_ADD;
          next_state = S_DECODE;
        end else if (timed_out) begin
          next_state = S_TRAP;
        end
      end
      S_DECODE: begin
        alusrcb = ALUSRCB_IMMSH;
        aluop   = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW:                      next_state = S_MEMADR;
          OP_RTYPE:                          next_state = funct_legal ? S_RTYPEEX : S_TRAP;
          OP_BEQ:                            next_state = S_BEQEX;
          OP_BNE:                            next_state = S_BNEEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: next_state = S_IMMEX;
          OP_J:                              next_state = S_JEX;
          OP_JAL:                            next_state = S_JALEX;
          default:                           next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = ALUSRCB_IMM;
        aluop      = ALUOP_ADD;
        next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready)      next_state = S_MEMWB;
        else if (timed_out) next_state = S_TRAP;
      end
      S_MEMWB: begin
        regwrite   = 1'b1;
        regdst     = REGDST_RT;
        memtoreg   = MEMTOREG_DATA;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready)      next_state = S_FETCH;
        else if (timed_out) next_state = S_TRAP;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alusrcb    = ALUSRCB_B;
        aluop      = ALUOP_FUNCT;
        next_state = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite   = 1'b1;
        regdst     = REGDST_RD;
        memtoreg   = MEMTOREG_ALUOUT;
        next_state = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca    = 1'b1;
        alusrcb    = ALUSRCB_B;
        aluop      = ALUOP_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = (state == S_BEQEX) ? zero : !zero;
        next_state = S_FETCH;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = ALUSRCB_IMM;
        aluop      = ALUOP_IMM;
        immext     = (op == OP_ANDI) || (op == OP_ORI);
        next_state = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite   = 1'b1;
        regdst     = REGDST_RT;
        memtoreg   = MEMTOREG_ALUOUT;
        next_state = S_FETCH;
      end
      S_JEX: begin
        pcen       = 1'b1;
        pcsrc      = PCSRC_JUMP;
        next_state = S_FETCH;
      end
      S_JALEX: begin
        pcen       = 1'b1;
        pcsrc      = PCSRC_JUMP;
        regwrite   = 1'b1;
        regdst     = REGDST_R31;
        memtoreg   = MEMTOREG_PC;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        fault      = 1'b1;
        next_state = S_TRAP;
      end
      default: next_state = S_TRAP;
    endcase

    if (reset) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      pcen     = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      iord     = 1'b0;
      immext   = 1'b0;
      regdst   = REGDST_RT;
      memtoreg = MEMTOREG_ALUOUT;
      alusrcb  = ALUSRCB_B;
      pcsrc    = PCSRC_ALURES;
      aluop    = ALUOP_NONE;
      fault    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_ctrl_ws.sv
// Self-checking bench for mips_mc_ctrl_ws: per-instruction expected cycle
// scripts derived from the instruction semantics, randomized instruction mix,
// wait states and don't-care inputs, plus a TIMEOUT=4 instance for trapping.
module tb_mips_mc_ctrl_ws;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       immext;
    logic [1:0] regdst;
    logic [1:0] memtoreg;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       fault;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset, mem_ready, zero;
  logic       t_reset, t_mem_ready;
  logic [5:0] op, funct;

  logic       mem_req, memwrite, pcen, irwrite, regwrite, alusrca, iord, immext, fault;
  logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       t_mem_req, t_memwrite, t_pcen, t_irwrite, t_regwrite, t_alusrca, t_iord, t_immext, t_fault;
  logic [1:0] t_regdst, t_memtoreg, t_alusrcb, t_pcsrc;
  logic [2:0] t_alucontrol;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] instret, t_instret;
  int          retired = 0;
`endif

  ctl_t got, t_got;
  assign got   = {mem_req, memwrite, pcen, irwrite, regwrite, alusrca, iord, immext,
                  regdst, memtoreg, alusrcb, pcsrc, alucontrol, fault};
  assign t_got = {t_mem_req, t_memwrite, t_pcen, t_irwrite, t_regwrite, t_alusrca, t_iord,
                  t_immext, t_regdst, t_memtoreg, t_alusrcb, t_pcsrc, t_alucontrol, t_fault};

  int checks = 0;
  int errors = 0;

  logic [5:0] op_tab    [12] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08,
                                 6'h0A, 6'h0C, 6'h0D, 6'h02, 6'h03, 6'h00};
  logic [5:0] bad_op    [4]  = '{6'h01, 6'h06, 6'h10, 6'h3F};
  logic [5:0] fn_tab    [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [5:0] bad_fn    [4]  = '{6'h21, 6'h26, 6'h27, 6'h00};

  always #5 clk = ~clk;

  mips_mc_ctrl_ws dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .pcen(pcen), .irwrite(irwrite),
    .regwrite(regwrite), .alusrca(alusrca), .iord(iord), .immext(immext),
    .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .fault(fault)
`ifdef MIPS_MC_PERF_EN
    , .instret(instret)
`endif
  );

  mips_mc_ctrl_ws #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(t_reset), .op(op), .funct(funct), .zero(zero), .mem_ready(t_mem_ready),
    .mem_req(t_mem_req), .memwrite(t_memwrite), .pcen(t_pcen), .irwrite(t_irwrite),
    .regwrite(t_regwrite), .alusrca(t_alusrca), .iord(t_iord), .immext(t_immext),
    .regdst(t_regdst), .memtoreg(t_memtoreg), .alusrcb(t_alusrcb), .pcsrc(t_pcsrc),
    .alucontrol(t_alucontrol), .fault(t_fault)
`ifdef MIPS_MC_PERF_EN
    , .instret(t_instret)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] o);
    case (o)
      6'h0A:   return 3'b111;
      6'h0C:   return 3'b000;
      6'h0D:   return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
  endfunction

  // One clock cycle of the main DUT: drive mem_ready, sample mid-cycle, advance.
  task automatic step(input string tag, input logic rdy, input ctl_t e);
    mem_ready = rdy;
    #4;
    check(tag, 32'(got), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ctl_t e;
    e = '0;
    reset = 1'b1;
    mem_ready = rnd();
    #4;
    check("reset_outputs", 32'(got), 32'(e));
    @(posedge clk);
    #1;
    reset = 1'b0;
`ifdef MIPS_MC_PERF_EN
    retired = 0;
    check("instret_reset", instret, 32'd0);
`endif
  endtask

  // Run one instruction from FETCH, with wf fetch waits and wm data waits.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int wf, input int wm);
    ctl_t e;
    bit   trapped;
    trapped = 1'b0;
    op = o;
    funct = f;
    zero = z;
    for (int i = 0; i <= wf; i++) begin
      e = '0;
      e.mem_req = 1'b1;
      if (i == wf) begin
        e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01; e.alucontrol = 3'b010;
      end
      step("fetch", i == wf, e);
    end
    e = '0; e.alusrcb = 2'b11; e.alucontrol = 3'b010;
    step("decode", rnd(), e);
    case (o)
      6'h23, 6'h2B: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = 3'b010;
        step("memadr", rnd(), e);
        for (int i = 0; i <= wm; i++) begin
          e = '0; e.mem_req = 1'b1; e.iord = 1'b1; e.memwrite = (o == 6'h2B);
          step((o == 6'h23) ? "memrd" : "memwr", i == wm, e);
        end
        if (o == 6'h23) begin
          e = '0; e.regwrite = 1'b1; e.memtoreg = 2'b01;
          step("memwb", rnd(), e);
        end
      end
      6'h00: begin
        if (funct_ok(f)) begin
          e = '0; e.alusrca = 1'b1; e.alucontrol = funct_alu(f);
          step("rtypeex", rnd(), e);
          e = '0; e.regwrite = 1'b1; e.regdst = 2'b01;
          step("rtypewb", rnd(), e);
        end else begin
          trapped = 1'b1;
        end
      end
      6'h04, 6'h05: begin
        e = '0; e.alusrca = 1'b1; e.alucontrol = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (o == 6'h04) ? z : !z;
        step("branch", rnd(), e);
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.alucontrol = imm_alu(o);
        e.immext = (o == 6'h0C) || (o == 6'h0D);
        step("immex", rnd(), e);
        e = '0; e.regwrite = 1'b1;
        step("immwb", rnd(), e);
      end
      6'h02: begin
        e = '0; e.pcen = 1'b1; e.pcsrc = 2'b10;
        step("jex", rnd(), e);
      end
      6'h03: begin
        e = '0; e.pcen = 1'b1; e.pcsrc = 2'b10; e.regwrite = 1'b1;
        e.regdst = 2'b10; e.memtoreg = 2'b10;
        step("jalex", rnd(), e);
      end
      default: trapped = 1'b1;
    endcase
    if (trapped) begin
      for (int i = 0; i < 3; i++) begin
        e = '0; e.fault = 1'b1;
        step("trap", rnd(), e);
      end
      do_reset();
    end else begin
`ifdef MIPS_MC_PERF_EN
      retired++;
      check("instret", instret, 32'(retired));
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl_t e;
    int   cnt;
    logic [5:0] o, f;
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = 6'h00; funct = 6'h20;
    t_reset = 1'b1; t_mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Directed cases.
    run_instr(6'h23, 6'h20, 1'b0, 0, 0);   // zero-wait LW
    run_instr(6'h2B, 6'h20, 1'b0, 0, 3);   // SW with 3 store waits
    run_instr(6'h05, 6'h20, 1'b1, 0, 0);   // BNE not taken
    run_instr(6'h05, 6'h20, 1'b0, 0, 0);   // BNE taken
    run_instr(6'h03, 6'h20, 1'b0, 0, 0);   // JAL
    run_instr(6'h0D, 6'h20, 1'b0, 0, 0);   // ORI
    run_instr(6'h3F, 6'h20, 1'b0, 0, 0);   // illegal opcode
    run_instr(6'h00, 6'h27, 1'b0, 0, 0);   // illegal funct

    // Ten legal instructions straight after a reset.
    for (int n = 0; n < 10; n++) begin
      o = op_tab[$urandom_range(0, 11)];
      run_instr(o, fn_tab[$urandom_range(0, 4)], rnd(), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Randomized instruction mix with occasional illegal encodings.
    for (int n = 0; n < 60; n++) begin
      o = ($urandom_range(0, 15) == 0) ? bad_op[$urandom_range(0, 3)] : op_tab[$urandom_range(0, 11)];
      f = ($urandom_range(0, 7) == 0) ? bad_fn[$urandom_range(0, 3)] : fn_tab[$urandom_range(0, 4)];
      run_instr(o, f, rnd(), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // With TIMEOUT=0 a 100-cycle stall in FETCH must not trap.
    do_reset();
    mem_ready = 1'b0;
    cnt = 0;
    e = '0; e.mem_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #4;
      if (got == e) cnt++;
      @(posedge clk);
      #1;
    end
    check("no_timeout_stall", 32'(cnt), 32'd100);
    do_reset();

    // TIMEOUT=4: three waits then ready completes normally.
    t_reset = 1'b1;
    @(posedge clk);
    #1;
    t_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t_mem_ready = (i == 3);
      e = '0; e.mem_req = 1'b1;
      if (i == 3) begin
        e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01; e.alucontrol = 3'b010;
      end
      #4;
      check("to_fetch_ok", 32'(t_got), 32'(e));
      @(posedge clk);
      #1;
    end
    t_mem_ready = 1'b0;
    e = '0; e.alusrcb = 2'b11; e.alucontrol = 3'b010;
    #4;
    check("to_decode", 32'(t_got), 32'(e));
    @(posedge clk);
    #1;

    // TIMEOUT=4: four stalled fetch cycles, then trapped until reset.
    t_reset = 1'b1;
    e = '0;
    #4;
    check("to_reset_outputs", 32'(t_got), 32'(e));
    @(posedge clk);
    #1;
    t_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = '0; e.mem_req = 1'b1;
      #4;
      check("to_wait", 32'(t_got), 32'(e));
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      t_mem_ready = 1'b1;
      e = '0; e.fault = 1'b1;
      #4;
      check("to_trap", 32'(t_got), 32'(e));
      @(posedge clk);
      #1;
    end
`ifdef MIPS_MC_PERF_EN
    check("to_instret", t_instret, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl_ws.md
# mips_mc_ctrl_ws

Multicycle MIPS control unit with a variable-latency memory handshake, an extended instruction set (BNE, SLTI, ANDI, ORI, JAL) and a configurable memory-timeout trap. It replaces the fixed-latency multicycle controller. It drives the existing multicycle datapath, which gains a zero-extend select, r31 write-address select and PC write-back select. A single unified instruction/data memory answers `mem_req` with `mem_ready`.

## Interface
Reset is synchronous, active-high. The block uses one clock `clk` and reset `reset`.

Parameters:
- `TIMEOUT`, 0: maximum wait cycles per memory access before trapping; 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter, used only with `MIPS_MC_PERF_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `op`  in  6  instruction[31:26] from the IR.
- `funct`  in  6  instruction[5:0] from the IR.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `memwrite`  out  1  write qualifier for `mem_req`.
- `pcen`  out  1  PC register enable.
- `irwrite`  out  1  IR load.
- `regwrite`  out  1  register-file write.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = A.
- `iord`  out  1  address select: 0 = PC, 1 = ALUOut.
- `immext`  out  1  immediate extension: 0 = sign, 1 = zero.
- `regdst`  out  2  write-address select: 00 = rt, 01 = rd, 10 = r31.
- `memtoreg`  out  2  write-data select: 00 = ALUOut, 01 = Data, 10 = PC.
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = Imm, 11 = Imm<<2.
- `pcsrc`  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `alucontrol`  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- `fault`  out  1  controller is trapped.
- `instret`  out  `CNT_W`  retired-instruction count; present only with `MIPS_MC_PERF_EN`.

## Operation
- **Supported opcodes:** LW 23h, SW 2Bh, R-type 00h, BEQ 04h, BNE 05h, ADDI 08h, SLTI 0Ah, ANDI 0Ch, ORI 0Dh, J 02h, JAL 03h.
- **Supported R-type funct values:** 20h add, 22h sub, 24h and, 25h or, 2Ah slt.
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, IMMEX, IMMWB, JEX, JALEX, TRAP.
- **FETCH:** `mem_req=1`, `iord=0`. When `mem_ready=1`: `irwrite=1`, `pcen=1`, `alusrcb=01`, `pcsrc=00`, `alucontrol=add`, go to DECODE. Otherwise hold with `irwrite=0` and `pcen=0`.
- **DECODE:** `alusrcb=11`, `alucontrol=add`, computing the branch target. Dispatch by opcode:
  - LW/SW go to MEMADR.
  - R-type goes to RTYPEEX if `funct` is legal, else TRAP.
  - BEQ goes to BEQEX; BNE goes to BNEEX.
  - ADDI, SLTI, ANDI and ORI go to IMMEX.
  - J goes to JEX; JAL goes to JALEX.
  - Any other opcode goes to TRAP.
- **MEMADR:** `alusrca=1`, `alusrcb=10`, `immext=0`, add. LW goes to MEMRD; SW goes to MEMWR.
- **MEMRD:** `mem_req=1`, `iord=1`. Advances to MEMWB on `mem_ready`.
- **MEMWB:** `regwrite=1`, `regdst=00`, `memtoreg=01`. Goes to FETCH.
- **MEMWR:** `mem_req=1`, `memwrite=1`, `iord=1` in every wait cycle. Goes to FETCH on `mem_ready`.
- **RTYPEEX:** `alusrca=1`, `alusrcb=00`, ALU operation decoded from `funct`.
- **RTYPEWB:** `regwrite=1`, `regdst=01`, `memtoreg=00`.
- **BEQEX / BNEEX:** `alusrca=1`, `alusrcb=00`, sub, `pcsrc=01`. `pcen` is asserted iff `zero` (BEQ) or `!zero` (BNE). Goes to FETCH.
- **IMMEX:** `alusrca=1`, `alusrcb=10`.
  - ADDI: add, `immext=0`.
  - SLTI: slt, `immext=0`.
  - ANDI: and, `immext=1`.
  - ORI: or, `immext=1`.
- **IMMWB:** `regwrite=1`, `regdst=00`, `memtoreg=00`.
- **JEX:** `pcen=1`, `pcsrc=10`.
- **JALEX:** `pcen=1`, `pcsrc=10`, `regwrite=1`, `regdst=10`, `memtoreg=10`. r31 receives the current PC (PC+4 of the JAL); the PC update occurs on the same edge.
- **Timeout:** a wait counter clears on every entry to FETCH, MEMRD or MEMWR. It increments each cycle in those states while `mem_ready=0`. If `TIMEOUT>0` and the counter reaches `TIMEOUT`, the next state is TRAP.
- **TRAP:** `fault=1`; all strobes and `mem_req` are 0. TRAP is left only by `reset`.
- **Unlisted outputs:** every output not named for a state is 0.

## Timing
- **Output type:** all control outputs are combinational from state, `op`, `funct`, `zero` and `mem_ready`. The only registers are the state, the wait counter and `instret`.
- **Cycles per instruction with zero-wait memory:** LW 5, SW 4, R-type 4, immediates 4, BEQ/BNE 3, J 3, JAL 3. Each memory wait cycle adds 1.
- **During reset:** all outputs are 0, including `mem_req` and `fault`.
- **After reset:** state=FETCH, wait counter 0, `instret` 0. The first `mem_req` is in the first cycle after `reset` deasserts.
- **Reset mid-access:** drops `mem_req` in the reset cycle. The memory must abandon the access.
- **`mem_ready` outside a request:** ignored.
- **Simultaneous `mem_ready` and timeout:** `mem_ready` wins.

## Configuration
- **`MIPS_MC_PERF_EN` defined:** the `instret` port exists. It increments by 1 on each transition into FETCH from a completing state: MEMWB, MEMWR+ready, RTYPEWB, IMMWB, BEQEX, BNEEX, JEX or JALEX. It wraps modulo 2^`CNT_W` and never counts TRAP.
- **`MIPS_MC_PERF_EN` undefined:** the port and counter are absent; behaviour is otherwise identical.

## Structure
- **Shared package `mips_mc_pkg`:** opcode and funct constants, the state enum (4 bits), ALU control codes, and `regdst`/`memtoreg`/`alusrcb`/`pcsrc` select codes.
- **Sub-module `mips_aludec_ext`:** combinational ALU decoder from an internal ALU-op field, `op` and `funct` to `alucontrol`, plus a `funct_legal` flag.

## Test plan
- **Zero-wait LW:** `mem_ready` tied 1, LW. Expect `mem_req` in cycles 1 and 4, `regwrite` with `memtoreg=01` in cycle 5, back to FETCH in cycle 6.
- **Waited SW:** SW with 3 wait cycles on the store. `memwrite=1` held for 4 cycles and falls after `mem_ready`; SW takes 7 cycles total.
- **BNE both ways:** BNE with `zero=1`, then with `zero=0`. Expect `pcen=0` in BNEEX, then `pcen=1` with `pcsrc=01`.
- **JAL and ORI:** JAL, then ORI. Expect JALEX `regdst=10`, `memtoreg=10`, `pcen=1`; ORI IMMEX with `immext=1` and `alucontrol=001`.
- **Illegal codes:** opcode 3Fh, and separately R-type funct 27h. Expect TRAP after DECODE, `fault=1`, all strobes 0 until `reset`.
- **Timeout:** `TIMEOUT=4` and `mem_ready` held 0 in FETCH gives TRAP after 4 wait cycles. With `TIMEOUT=0`, `mem_ready` held low for 100 cycles causes no trap. With `MIPS_MC_PERF_EN` defined, 10 retired instructions read `instret=10`.
